vpu_pixel_stream_out: RTL

//  Downstream of the BG pipeline colour-merge stage: takes the merged ARGB8888 pixel

---
 rtl/vpu_pixel_stream_out.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/vpu_pixel_stream_out.sv
// Pixel stream output stage: buffers merged ARGB8888 pixels, drops alpha, formats them,
// tags frame/line boundaries and presents them on a ready/valid scan-out interface.
module vpu_pixel_stream_out #(
  parameter int unsigned LINE_W     = 320,
  parameter int unsigned FRAME_H    = 240,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned OUT_FMT    = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            pix_valid,
  input  logic [31:0]                     pix_color,
  input  logic                            pix_sof,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [23:0]                     out_data,
  output logic                            out_sof,
  output logic                            out_eol,
  output logic                            frame_done,
  input  logic                            clr_status,
  output logic                            overflow,
  output logic                            sync_err,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned XW = $clog2(LINE_W);
  localparam int unsigned YW = $clog2(FRAME_H);
  localparam logic [XW-1:0] X_LAST = XW'(LINE_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(FRAME_H - 1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);

  // One buffered pixel: last marks the final pixel of a frame (drives frame_done).
  typedef struct packed {
    logic        last;
    logic        sof;
    logic        eol;
    logic [23:0] data;
  } entry_t;

  entry_t          mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   level;
  logic [XW-1:0]   wx;
  logic [YW-1:0]   wy;
  logic            out_last;

  logic            pop_c;
  logic            full_c;
  logic            push_c;
  logic            drop_c;
  logic            at_origin_c;
  logic            resync_c;
  logic            load_c;
  logic [LW-1:0]   avail_c;
  logic [AW-1:0]   head_c;
  logic [XW-1:0]   wx_nxt_c;
  logic [YW-1:0]   wy_nxt_c;
  entry_t          entry_c;

  // Alpha is discarded; RGB565 truncates each channel without rounding.
  function automatic logic [23:0] fmt_pix(input logic [31:0] c);
    if (OUT_FMT == 1) return {8'h00, c[23:19], c[15:10], c[7:3]};
    else              return c[23:0];
  endfunction

  assign fifo_level = level;

  // Handshake decode: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    pop_c       = out_valid & out_ready;
    full_c      = (level == LVL_FULL);
    push_c      = pix_valid & (~full_c | pop_c);
    drop_c      = pix_valid & full_c & ~pop_c;
    at_origin_c = (wx == '0) && (wy == '0);
    resync_c    = push_c & pix_sof & ~at_origin_c;
    load_c      = ~out_valid | pop_c;
    avail_c     = level - LW'(pop_c);
    head_c      = rd_ptr + AW'(pop_c);
  end

  // Build the FIFO entry and the next write position (dropped pixels still advance).
  always_comb begin
    entry_c.data = fmt_pix(pix_color);
    entry_c.sof  = at_origin_c;
    entry_c.eol  = (wx == X_LAST);
    entry_c.last = (wx == X_LAST) && (wy == Y_LAST);
    wx_nxt_c     = wx;
    wy_nxt_c     = wy;
    if (resync_c) begin
      entry_c.sof  = 1'b1;
      entry_c.eol  = 1'b0;
      entry_c.last = 1'b0;
      wx_nxt_c     = XW'(1);
      wy_nxt_c     = '0;
    end else if (pix_valid) begin
      if (wx == X_LAST) begin
        wx_nxt_c = '0;
        wy_nxt_c = (wy == Y_LAST) ? '0 : wy + YW'(1);
      end else begin
        wx_nxt_c = wx + XW'(1);
      end
    end
  end

  // FIFO storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_c) mem[wr_ptr] <= entry_c;
  end

  // Write position, pointers and occupancy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wx     <= '0;
      wy     <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wx    <= wx_nxt_c;
      wy    <= wy_nxt_c;
      level <= level + LW'(push_c) - LW'(pop_c);
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Registered head view: reloads when empty or on pop, holds while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sof    <= 1'b0;
      out_eol    <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (load_c) begin
        out_valid <= (avail_c != '0);
        if (avail_c != '0) begin
          out_data <= mem[head_c].data;
          out_sof  <= mem[head_c].sof;
          out_eol  <= mem[head_c].eol;
          out_last <= mem[head_c].last;
        end
      end
      frame_done <= pop_c & out_last;
    end
  end

  // Sticky status; a set event wins over a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      if (drop_c)          overflow <= 1'b1;
      else if (clr_status) overflow <= 1'b0;
      if (resync_c)        sync_err <= 1'b1;
      else if (clr_status) sync_err <= 1'b0;
    end
  end

endmodule
